// File: rtl/wbus_serial_tx.sv
// W-bus write sink: buffers {addr,data} writes in a FIFO and emits each entry as a
// framed serial word (start, addr, data, even parity, stop), paced by BIT_DIV.
module wbus_serial_tx #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned BIT_DIV = 4,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          wa_addr,
    input  logic [DATA_W-1:0]          wa_data_wr,
    input  logic                       wa_wr_s,
    input  logic                       ser_rdy,
    input  logic                       ovf_clr,
    output logic                       ser_out,
    output logic                       ser_busy,
    output logic                       wa_full,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       ovf
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = $clog2(DEPTH + 1);
    localparam int unsigned PayW = ADDR_W + DATA_W;
    localparam int unsigned DivW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam int unsigned MaxW = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int unsigned BitW = (MaxW > 1) ? $clog2(MaxW) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StAddr,
        StData,
        StParity,
        StStop
    } state_e;

    logic [PayW-1:0] mem [DEPTH];
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [LvlW-1:0] level_q;
    logic            ovf_q;

    state_e          state_q;
    logic [DivW-1:0] div_q;
    logic [BitW-1:0] bit_q;
    logic [PayW-1:0] shift_q;
    logic            par_q;
    logic            ser_q;

    logic full, push, pop, bit_end;

    assign full    = (level_q == LvlW'(DEPTH));
    assign pop     = (state_q == StIdle) && (level_q != '0) && ser_rdy;
    // A pop on the same edge frees a slot, so a write into a full FIFO still lands.
    assign push    = wa_wr_s && (!full || pop);
    assign bit_end = (div_q == DivW'(BIT_DIV - 1));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= {wa_addr, wa_data_wr};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
            if (wa_wr_s && !push) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            ser_q   <= 1'b1;
        end else begin
            if (state_q == StIdle || bit_end) begin
                div_q <= '0;
            end else begin
                div_q <= div_q + 1'b1;
            end

            // ser_q is loaded with the bit belonging to the state being entered.
            unique case (state_q)
                StIdle: begin
                    ser_q <= 1'b1;
                    if (pop) begin
                        state_q <= StStart;
                        shift_q <= mem[rptr_q];
                        par_q   <= ^mem[rptr_q];
                        ser_q   <= 1'b0;
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        state_q <= StAddr;
                        bit_q   <= '0;
                        ser_q   <= shift_q[PayW-1];
                    end
                end
                StAddr: begin
                    if (bit_end) begin
                        shift_q <= shift_q << 1;
                        ser_q   <= shift_q[PayW-2];
                        if (bit_q == BitW'(ADDR_W - 1)) begin
                            state_q <= StData;
                            bit_q   <= '0;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end
                end
                StData: begin
                    if (bit_end) begin
                        shift_q <= shift_q << 1;
                        if (bit_q == BitW'(DATA_W - 1)) begin
                            state_q <= StParity;
                            bit_q   <= '0;
                            ser_q   <= par_q;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                            ser_q <= shift_q[PayW-2];
                        end
                    end
                end
                StParity: begin
                    if (bit_end) begin
                        state_q <= StStop;
                        ser_q   <= 1'b1;
                    end
                end
                StStop: begin
                    if (bit_end) begin
                        state_q <= StIdle;
                        ser_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    ser_q   <= 1'b1;
                end
            endcase
        end
    end

    assign ser_out  = ser_q;
    assign ser_busy = (state_q != StIdle);
    assign wa_full  = full;
    assign level    = level_q;
    assign ovf      = ovf_q;

endmodule
